// File: rtl/rsa_modexp_pkg.sv
// Shared definitions for the modular exponentiator: FSM encoding and
// Montgomery operation latency.
package rsa_modexp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_X,
    ST_PRE_A,
    ST_SQUARE,
    ST_MULT,
    ST_POST,
    ST_DONE
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int OP_CYCLES = DEF_WIDTH + 3;

  // Cycles per Montgomery operation: issue, WIDTH iterations, correction, capture.
  function automatic int op_cycles(input int width);
    return width + 3;
  endfunction

endpackage

// File: rtl/rsa_modexp_if.sv
// Command/operand/result bundle between the SPI register wrapper and the
// exponentiator.
interface rsa_modexp_if #(parameter int WIDTH = 8);

  logic             ena;
  logic             start_cmd;
  logic             stop_cmd;
  logic [WIDTH-1:0] rsa_p;
  logic [WIDTH-1:0] rsa_e;
  logic [WIDTH-1:0] rsa_m;
  logic [WIDTH-1:0] rsa_const;
  logic [WIDTH-1:0] rsa_c;
  logic             eoc;
  logic             busy;

  modport master (
    output ena, start_cmd, stop_cmd, rsa_p, rsa_e, rsa_m, rsa_const,
    input  rsa_c, eoc, busy
  );

  modport slave (
    input  ena, start_cmd, stop_cmd, rsa_p, rsa_e, rsa_m, rsa_const,
    output rsa_c, eoc, busy
  );

endinterface

// File: rtl/rsa_modexp_mont_mult.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod p.
// done pulses WIDTH+2 enabled cycles after start; result holds until the next start.
module mont_mult
  import rsa_modexp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int            CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_LOAD = CW'(op_cycles(WIDTH) - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] t_add;
  logic [WIDTH+1:0] t_odd;
  logic [WIDTH+1:0] t_iter;
  logic [WIDTH+1:0] p_ext;

  always_comb begin
    p_ext  = {2'b00, p_r};
    t_add  = a_sh[0] ? (t + {2'b00, b_r}) : t;
    t_odd  = t_add[0] ? (t_add + p_ext) : t_add;
    t_iter = t_odd >> 1;
  end

  // cnt: WIDTH+1 down to 2 are iterations, 1 is the final correction.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_r    <= '0;
      p_r    <= '0;
      t      <= '0;
      result <= '0;
      done   <= 1'b0;
    end else if (ena) begin
      done <= 1'b0;
      if (clear) begin
        cnt    <= '0;
        a_sh   <= '0;
        b_r    <= '0;
        p_r    <= '0;
        t      <= '0;
        result <= '0;
      end else if (start) begin
        cnt  <= CNT_LOAD;
        a_sh <= a;
        b_r  <= b;
        p_r  <= p;
        t    <= '0;
      end else if (cnt > CNT_ONE) begin
        t    <= t_iter;
        a_sh <= a_sh >> 1;
        cnt  <= cnt - CNT_ONE;
      end else if (cnt == CNT_ONE) begin
        result <= (t >= p_ext) ? WIDTH'(t - p_ext) : t[WIDTH-1:0];
        done   <= 1'b1;
        cnt    <= '0;
      end
    end
  end

endmodule

// File: rtl/rsa_modexp.sv
// Modular exponentiation c = m^e mod p by left-to-right square-and-multiply
// in the Montgomery domain.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for start_cmd
// ST_PRE_X  | x = mont(m, const), message into Montgomery domain
// ST_PRE_A  | a = mont(1, const), accumulator = R mod p
// ST_SQUARE | a = mont(a, a) for exponent bit k
// ST_MULT   | a = mont(a, x) when e[k] = 1
// ST_POST   | a = mont(a, 1), leave Montgomery domain
// ST_DONE   | rsa_c <= a, eoc pulse
module rsa_modexp
  import rsa_modexp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rstb,
  rsa_modexp_if.slave bus
);

  localparam int               KW    = $clog2(WIDTH);
  localparam logic [KW-1:0]    K_TOP = KW'(WIDTH - 1);
  localparam logic [KW-1:0]    K_ONE = KW'(1);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic             issued, issued_nxt;
  logic [KW-1:0]    k, k_nxt;
  logic [WIDTH-1:0] p_r, e_r, m_r, const_r;
  logic [WIDTH-1:0] x_r, a_r, c_q;
  logic             load_ops, cap_x, cap_a, load_c, eoc_int;
  logic             mm_start, mm_clear, mm_done;
  logic [WIDTH-1:0] mm_a, mm_b, mm_result;

  mont_mult #(.WIDTH(WIDTH)) u_mult (
    .clk    (clk),
    .rstb   (rstb),
    .ena    (bus.ena),
    .clear  (mm_clear),
    .start  (mm_start),
    .a      (mm_a),
    .b      (mm_b),
    .p      (p_r),
    .result (mm_result),
    .done   (mm_done)
  );

  always_comb begin
    state_nxt  = state;
    issued_nxt = issued;
    k_nxt      = k;
    load_ops   = 1'b0;
    cap_x      = 1'b0;
    cap_a      = 1'b0;
    load_c     = 1'b0;
    eoc_int    = 1'b0;
    mm_start   = 1'b0;
    mm_clear   = 1'b0;
    mm_a       = a_r;
    mm_b       = a_r;

    case (state)
      ST_PRE_X: begin mm_a = m_r; mm_b = const_r; end
      ST_PRE_A: begin mm_a = ONE; mm_b = const_r; end
      ST_MULT:  mm_b = x_r;
      ST_POST:  mm_b = ONE;
      default:  ;
    endcase

    // Stop outranks start in IDLE and outranks the eoc in DONE.
    if (state == ST_IDLE) begin
      if (bus.start_cmd && !bus.stop_cmd) begin
        load_ops  = 1'b1;
        k_nxt     = K_TOP;
        state_nxt = ST_PRE_X;
      end
    end else if (bus.stop_cmd) begin
      state_nxt  = ST_IDLE;
      issued_nxt = 1'b0;
      mm_clear   = 1'b1;
    end else if (state == ST_DONE) begin
      eoc_int   = 1'b1;
      load_c    = 1'b1;
      state_nxt = ST_IDLE;
    end else if (!issued) begin
      mm_start   = 1'b1;
      issued_nxt = 1'b1;
    end else if (mm_done) begin
      issued_nxt = 1'b0;
      case (state)
        ST_PRE_X: begin
          cap_x     = 1'b1;
          state_nxt = ST_PRE_A;
        end
        ST_PRE_A: begin
          cap_a     = 1'b1;
          state_nxt = ST_SQUARE;
        end
        ST_SQUARE: begin
          cap_a = 1'b1;
          if (e_r[k])          state_nxt = ST_MULT;
          else if (k != '0)    k_nxt     = k - K_ONE;
          else                 state_nxt = ST_POST;
        end
        ST_MULT: begin
          cap_a = 1'b1;
          if (k != '0) begin
            k_nxt     = k - K_ONE;
            state_nxt = ST_SQUARE;
          end else begin
            state_nxt = ST_POST;
          end
        end
        ST_POST: begin
          cap_a     = 1'b1;
          state_nxt = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= ST_IDLE;
      issued  <= 1'b0;
      k       <= '0;
      p_r     <= '0;
      e_r     <= '0;
      m_r     <= '0;
      const_r <= '0;
      x_r     <= '0;
      a_r     <= '0;
      c_q     <= '0;
    end else if (bus.ena) begin
      state  <= state_nxt;
      issued <= issued_nxt;
      k      <= k_nxt;
      if (load_ops) begin
        p_r     <= bus.rsa_p;
        e_r     <= bus.rsa_e;
        m_r     <= bus.rsa_m;
        const_r <= bus.rsa_const;
      end
      if (cap_x)  x_r <= mm_result;
      if (cap_a)  a_r <= mm_result;
      if (load_c) c_q <= a_r;
    end
  end

  assign bus.rsa_c = c_q;
  assign bus.busy  = (state != ST_IDLE);
  assign bus.eoc   = eoc_int && bus.ena;

endmodule

// File: tb/tb_rsa_modexp.sv
// Self-checking bench for rsa_modexp: directed corner cases plus random
// operands compared against a plain-arithmetic modular exponentiation model.
module tb_rsa_modexp;

  localparam int W         = 8;
  localparam int ACT_NONE  = 0;
  localparam int ACT_M     = 1;
  localparam int ACT_START = 2;
  localparam int ACT_STOP  = 3;
  localparam int ACT_ENA   = 4;
  localparam int ACT_RST   = 5;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  rsa_modexp_if #(.WIDTH(W)) bus ();

  rsa_modexp #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_c(input int p, input int e, input int m);
    longint r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * longint'(m)) % longint'(p);
    return int'(r);
  endfunction

  function automatic int model_const(input int p);
    return int'((64'd1 << (2 * W)) % longint'(p));
  endfunction

  function automatic int model_lat(input int e);
    int pop;
    pop = 0;
    for (int i = 0; i < W; i++) pop += (e >> i) & 1;
    return (3 + W + pop) * (W + 3) + 1;
  endfunction

  // Launch one exponentiation, optionally disturbing it at cycle act_at
  // (cycle 0 is the start_cmd cycle), and check the outcome.
  task automatic run_op(input string tag, input int p, input int e, input int m,
                        input int act, input int act_at);
    int         cyc, lat, budget, stop_cyc, busy_low;
    bit         seen;
    logic [W-1:0] c_prev;
    c_prev   = bus.rsa_c;
    lat      = model_lat(e) + ((act == ACT_ENA) ? 20 : 0);
    budget   = lat + 30;
    seen     = 1'b0;
    stop_cyc = -1;
    busy_low = 0;
    @(negedge clk);
    bus.rsa_p     = W'(p);
    bus.rsa_e     = W'(e);
    bus.rsa_m     = W'(m);
    bus.rsa_const = W'(model_const(p));
    bus.start_cmd = 1'b1;
    cyc = 0;
    while (cyc < budget && !seen) begin
      @(negedge clk);
      cyc++;
      bus.start_cmd = 1'b0;
      bus.stop_cmd  = 1'b0;
      if (cyc == act_at) begin
        case (act)
          ACT_M:     bus.rsa_m = W'(7);
          ACT_START: bus.start_cmd = 1'b1;
          ACT_STOP: begin
            bus.stop_cmd = 1'b1;
            stop_cyc     = cyc;
          end
          ACT_ENA: begin
            bus.ena = 1'b0;
            repeat (20) @(negedge clk);
            bus.ena = 1'b1;
            cyc += 20;
          end
          ACT_RST: begin
            rstb = 1'b0;
            #1;
            check({tag, "/rst_c"},    32'(bus.rsa_c), 0);
            check({tag, "/rst_busy"}, 32'(bus.busy), 0);
            check({tag, "/rst_eoc"},  32'(bus.eoc), 0);
            @(negedge clk);
            rstb = 1'b1;
            return;
          end
          default: ;
        endcase
      end
      #1;
      if (bus.eoc) seen = 1'b1;
      if (stop_cyc < 0 && !bus.busy) busy_low++;
      if (stop_cyc >= 0 && cyc == stop_cyc + 1) check({tag, "/busy_after_stop"}, 32'(bus.busy), 0);
    end
    if (stop_cyc >= 0) begin
      check({tag, "/no_eoc"},  32'(seen), 0);
      check({tag, "/c_kept"},  32'(bus.rsa_c), 32'(c_prev));
      check({tag, "/idle"},    32'(bus.busy), 0);
    end else begin
      check({tag, "/eoc_seen"}, 32'(seen), 1);
      check({tag, "/latency"},  32'(cyc), 32'(lat));
      check({tag, "/busy_gap"}, 32'(busy_low), 0);
      @(negedge clk);
      #1;
      check({tag, "/eoc_width"}, 32'(bus.eoc), 0);
      check({tag, "/result"},    32'(bus.rsa_c), 32'(model_c(p, e, m)));
      check({tag, "/busy_end"},  32'(bus.busy), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, e, m;
    bus.ena       = 1'b1;
    bus.start_cmd = 1'b0;
    bus.stop_cmd  = 1'b0;
    bus.rsa_p     = '0;
    bus.rsa_e     = '0;
    bus.rsa_m     = '0;
    bus.rsa_const = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset/c",    32'(bus.rsa_c), 0);
    check("reset/eoc",  32'(bus.eoc), 0);
    check("reset/busy", 32'(bus.busy), 0);
    @(negedge clk);
    rstb = 1'b1;

    run_op("p13_m4_e3",   13,  3, 4, ACT_NONE, 0);
    run_op("p251_mchg",  251, 10, 2, ACT_M, 20);
    run_op("e_zero",      13,  0, 5, ACT_NONE, 0);
    run_op("m_zero",      13,  5, 0, ACT_NONE, 0);
    run_op("p13_again",   13,  3, 4, ACT_NONE, 0);
    run_op("stop_50",    251, 10, 2, ACT_STOP, 50);
    run_op("start_busy",  13,  3, 4, ACT_START, 30);
    run_op("ena_hold",    13,  3, 4, ACT_ENA, 60);
    run_op("stop_done",  251, 10, 2, ACT_STOP, model_lat(10));

    @(negedge clk);
    bus.start_cmd = 1'b1;
    bus.stop_cmd  = 1'b1;
    @(negedge clk);
    bus.start_cmd = 1'b0;
    bus.stop_cmd  = 1'b0;
    #1;
    check("start_stop_idle/busy", 32'(bus.busy), 0);

    @(negedge clk);
    bus.ena       = 1'b0;
    bus.start_cmd = 1'b1;
    @(negedge clk);
    bus.start_cmd = 1'b0;
    bus.ena       = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("start_ena0/busy", 32'(bus.busy), 0);

    run_op("rst_mid",     13,  3, 4, ACT_RST, 70);
    run_op("after_rst",   13,  3, 4, ACT_NONE, 0);

    for (int i = 0; i < 24; i++) begin
      p = 2 * $urandom_range(1, 127) + 1;
      m = $urandom_range(0, p - 1);
      e = $urandom_range(0, 255);
      run_op($sformatf("rand%0d", i), p, e, m, ACT_NONE, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
